// File: rtl/breakout_pixel_renderer_pkg.sv
// Shared definitions for the Breakout pixel renderer: default colours,
// run-state encoding and small elaboration-time helpers.
package breakout_pkg;

    localparam logic [23:0] COLOR_RED    = 24'hFF0000;
    localparam logic [23:0] COLOR_WHITE  = 24'hFFFFFF;
    localparam logic [23:0] COLOR_YELLOW = 24'hFFFF00;

    // Two legal encodings; the other two fall back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01
    } run_state_e;

    // Linear brick number in the alive bitmap.
    function automatic int brick_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

    // Ceiling log2, usable in localparam expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width of an index/counter that must be at least one bit wide.
    function automatic int width_min1(input int v);
        int w;
        w = clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/breakout_pixel_renderer_if.sv
// Pixel stream and game-state bundle between the VGA timing / game logic
// side (master) and the renderer (slave).
//
// Stream semantics: there is no ready/back-pressure. pix_valid qualifies
// x/y in the same cycle and every valid pixel is accepted; out_valid
// qualifies color exactly two cycles later. frame_start is a one-cycle
// pulse. Ball, paddle and alive are expected to be stable across a frame.
interface breakout_pixel_renderer_if #(
    parameter int XW   = 10,
    parameter int ROWS = 3,
    parameter int COLS = 8
);
    logic                 pix_valid;
    logic                 frame_start;
    logic [XW-1:0]        x;
    logic [XW-1:0]        y;
    logic [XW-1:0]        ballx;
    logic [XW-1:0]        bally;
    logic [XW-1:0]        paddlex;
    logic [XW-1:0]        paddley;
    logic [ROWS*COLS-1:0] alive;
    logic                 out_valid;
    logic [23:0]          color;

    modport master (
        output pix_valid, frame_start, x, y, ballx, bally, paddlex, paddley, alive,
        input  out_valid, color
    );

    modport slave (
        input  pix_valid, frame_start, x, y, ballx, bally, paddlex, paddley, alive,
        output out_valid, color
    );

endinterface

// File: rtl/breakout_pixel_renderer_flash_ctr.sv
// Per-brick destruction flash counter, advanced once per frame.
// Loads FLASH_FRAMES when the brick disappears, clears while the brick is
// present, otherwise counts down to zero. flash_o is the blink phase bit.
module brick_flash_ctr #(
    parameter int FLASH_FRAMES = 8,
    parameter int CW           = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start_i,
    input  logic alive_q_i,
    input  logic alive_i,
    output logic flash_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: only frame boundaries change it.
    always_comb begin
        cnt_d = cnt_q;
        if (frame_start_i) begin
            if (alive_q_i && !alive_i) begin
                cnt_d = CW'(FLASH_FRAMES);
            end else if (alive_i) begin
                cnt_d = '0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign flash_o = cnt_q[0];

endmodule

// File: rtl/breakout_pixel_renderer.sv
// Two-stage pixel colour generator for the Breakout display path.
// Stage 1 classifies the scan coordinate (paddle, ball, brick, flash) using
// the frame-latched brick state; stage 2 applies priority and run gating.
module breakout_pixel_renderer
    import breakout_pkg::*;
#(
    parameter int          XW           = 10,
    parameter int          ROWS         = 3,
    parameter int          COLS         = 8,
    parameter int          BLK_W        = 80,
    parameter int          BLK_H        = 50,
    parameter int          GRID_X0      = 0,
    parameter int          GRID_Y0      = 40,
    parameter int          PAD_W        = 160,
    parameter int          PAD_H        = 10,
    parameter int          BALL_R       = 3,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [23:0] COLOR_A      = COLOR_RED,
    parameter logic [23:0] COLOR_B      = COLOR_WHITE,
    parameter logic [23:0] COLOR_HI     = COLOR_WHITE,
    parameter logic [23:0] COLOR_FLASH  = COLOR_YELLOW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_n,
    output run_state_e state_o,
    breakout_pixel_renderer_if.slave bus
);

    localparam int NB  = ROWS * COLS;
    localparam int SW  = XW + 2;
    localparam int RW  = width_min1(ROWS);
    localparam int CLW = width_min1(COLS);
    localparam int IW  = width_min1(NB);
    localparam int CW  = width_min1(FLASH_FRAMES + 1);

    // Two guard bits keep ballx-BALL_R and paddlex+PAD_W from wrapping.
    typedef logic signed [SW-1:0] sc_t;

    run_state_e    state_q;
    logic [NB-1:0] alive_q;
    logic [NB-1:0] flash_bit;

    // ---- stage 1 combinational classification ----
    sc_t            xs, ys, bxs, bys, pxs, pys;
    sc_t            col_base, row_base;
    logic [CLW-1:0] col_d;
    logic [RW-1:0]  row_d;
    logic [IW-1:0]  idx_d;
    logic           in_grid_d, brick_in_d;
    logic           pad_d, ball_d, live_d, flash_d, odd_d;

    // ---- stage 1 registers ----
    logic v1_q, pad_q, ball_q, live_q, flash_q, odd_q;

    // ---- stage 2 registers ----
    logic        out_valid_q;
    logic [23:0] color_q;

    assign xs  = $signed({2'b00, bus.x});
    assign ys  = $signed({2'b00, bus.y});
    assign bxs = $signed({2'b00, bus.ballx});
    assign bys = $signed({2'b00, bus.bally});
    assign pxs = $signed({2'b00, bus.paddlex});
    assign pys = $signed({2'b00, bus.paddley});

    // Run/idle control: leaves IDLE on the first sampled start_n low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (!start_n) state_q <= ST_RUN;
                ST_RUN:  state_q <= ST_RUN;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state_o = state_q;

    // Brick bitmap is frozen per frame so a frame renders consistently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 alive_q <= '1;
        else if (bus.frame_start) alive_q <= bus.alive;
    end

    for (genvar b = 0; b < NB; b++) begin : g_flash
        brick_flash_ctr #(
            .FLASH_FRAMES (FLASH_FRAMES),
            .CW           (CW)
        ) u_ctr (
            .clk           (clk),
            .rst           (rst),
            .frame_start_i (bus.frame_start),
            .alive_q_i     (alive_q[b]),
            .alive_i       (bus.alive[b]),
            .flash_o       (flash_bit[b])
        );
    end

    // Grid column/row by a constant compare chain (no divider).
    always_comb begin
        col_d    = '0;
        col_base = sc_t'(GRID_X0);
        for (int c = 1; c < COLS; c++) begin
            if (xs >= sc_t'(GRID_X0 + c * BLK_W)) begin
                col_d    = CLW'(c);
                col_base = sc_t'(GRID_X0 + c * BLK_W);
            end
        end
        row_d    = '0;
        row_base = sc_t'(GRID_Y0);
        for (int r = 1; r < ROWS; r++) begin
            if (ys >= sc_t'(GRID_Y0 + r * BLK_H)) begin
                row_d    = RW'(r);
                row_base = sc_t'(GRID_Y0 + r * BLK_H);
            end
        end
    end

    // Hit tests and brick lookup against the pre-update frame state.
    always_comb begin
        pad_d = (xs > pxs) && (xs < pxs + sc_t'(PAD_W)) &&
                (ys > pys) && (ys < pys + sc_t'(PAD_H));
        ball_d = (xs > bxs - sc_t'(BALL_R)) && (xs < bxs + sc_t'(BALL_R)) &&
                 (ys > bys - sc_t'(BALL_R)) && (ys < bys + sc_t'(BALL_R));
        in_grid_d = (xs >= sc_t'(GRID_X0)) && (xs < sc_t'(GRID_X0 + COLS * BLK_W)) &&
                    (ys >= sc_t'(GRID_Y0)) && (ys < sc_t'(GRID_Y0 + ROWS * BLK_H));
        // Strict lower bound leaves a one-pixel gutter on left/top edges.
        brick_in_d = in_grid_d &&
                     (xs > col_base) && (xs < col_base + sc_t'(BLK_W)) &&
                     (ys > row_base) && (ys < row_base + sc_t'(BLK_H));
        idx_d   = IW'(brick_idx(int'(row_d), int'(col_d), COLS));
        live_d  = brick_in_d && alive_q[idx_d];
        flash_d = brick_in_d && !alive_q[idx_d] && flash_bit[idx_d];
        odd_d   = row_d[0] ^ col_d[0];
    end

    // Stage 1 register: classification flags plus valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q    <= 1'b0;
            pad_q   <= 1'b0;
            ball_q  <= 1'b0;
            live_q  <= 1'b0;
            flash_q <= 1'b0;
            odd_q   <= 1'b0;
        end else begin
            v1_q    <= bus.pix_valid;
            pad_q   <= pad_d;
            ball_q  <= ball_d;
            live_q  <= live_d;
            flash_q <= flash_d;
            odd_q   <= odd_d;
        end
    end

    // Stage 2 register: priority colour select, blanked while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            color_q     <= '0;
        end else begin
            out_valid_q <= v1_q;
            if (state_q != ST_RUN) color_q <= '0;
            else if (pad_q)        color_q <= COLOR_HI;
            else if (ball_q)       color_q <= COLOR_HI;
            else if (live_q)       color_q <= odd_q ? COLOR_B : COLOR_A;
            else if (flash_q)      color_q <= COLOR_FLASH;
            else                   color_q <= '0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.color     = color_q;

endmodule

// File: tb/tb_breakout_pixel_renderer.sv
// Bench for breakout_pixel_renderer: fixed vectors, flash/reset sequences
// and random traffic against a coordinate-arithmetic reference model.
module tb_breakout_pixel_renderer;
    import breakout_pkg::*;

    localparam int XW = 10, ROWS = 3, COLS = 8, NB = ROWS * COLS;
    localparam int BLK_W = 80, BLK_H = 50, GRID_X0 = 0, GRID_Y0 = 40;
    localparam int PAD_W = 160, PAD_H = 10, BALL_R = 3, FLASH_FRAMES = 8;
    localparam logic [23:0] C_A = 24'hFF0000, C_B = 24'hFFFFFF;
    localparam logic [23:0] C_HI = 24'hFFFFFF, C_FL = 24'hFFFF00;

    // ---- clock / reset ----
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_n = 1'b1;
    run_state_e state;
    always #5 clk = ~clk;

    breakout_pixel_renderer_if #(.XW(XW), .ROWS(ROWS), .COLS(COLS)) bus ();

    breakout_pixel_renderer dut (
        .clk     (clk),
        .rst     (rst),
        .start_n (start_n),
        .state_o (state),
        .bus     (bus)
    );

    // ---- scoreboard / model state ----
    logic [24:0]   exp_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            m_run;
    bit [NB-1:0]   m_alive;
    int            m_flash[NB];

    typedef struct {
        int          px, py, bx, by, padx, pady;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        m_run   = 1'b0;
        m_alive = '1;
        for (int b = 0; b < NB; b++) m_flash[b] = 0;
    endtask

    // Colour from first principles: geometry by division and remainder.
    function automatic logic [23:0] model_color(input int px, input int py, input bit run);
        int bx, by, padx, pady, dx, dy, c, r, b;
        bx = int'(bus.ballx); by = int'(bus.bally);
        padx = int'(bus.paddlex); pady = int'(bus.paddley);
        if (!run) return 24'h0;
        if (px > padx && px < padx + PAD_W && py > pady && py < pady + PAD_H) return C_HI;
        if (px > bx - BALL_R && px < bx + BALL_R && py > by - BALL_R && py < by + BALL_R) return C_HI;
        if (px >= GRID_X0 && py >= GRID_Y0) begin
            dx = px - GRID_X0; dy = py - GRID_Y0;
            c = dx / BLK_W;    r = dy / BLK_H;
            if (c < COLS && r < ROWS && (dx % BLK_W) != 0 && (dy % BLK_H) != 0) begin
                b = r * COLS + c;
                if (m_alive[b]) return (((r + c) % 2) == 0) ? C_A : C_B;
                if ((m_flash[b] % 2) == 1) return C_FL;
            end
        end
        return 24'h0;
    endfunction

    task automatic model_frame();
        for (int b = 0; b < NB; b++) begin
            if (m_alive[b] && !bus.alive[b]) m_flash[b] = FLASH_FRAMES;
            else if (bus.alive[b])           m_flash[b] = 0;
            else if (m_flash[b] > 0)         m_flash[b] = m_flash[b] - 1;
        end
        m_alive = bus.alive;
    endtask

    // ---- driver: one clock with scoreboard push/compare ----
    task automatic tick();
        logic [24:0] e;
        bit run_n;
        run_n = m_run || !start_n;
        e = {bus.pix_valid, model_color(int'(bus.x), int'(bus.y), run_n)};
        exp_q.push_back(e);
        m_run = run_n;
        if (bus.frame_start) model_frame();
        @(posedge clk);
        #1;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check("sb_out_valid", 32'(bus.out_valid), 32'(e[24]));
            if (e[24]) check("sb_color", 32'(bus.color), 32'(e[23:0]));
        end
    endtask

    task automatic probe(input int px, input int py, input string name, input logic [23:0] exp);
        bus.x = XW'(px); bus.y = XW'(py); bus.pix_valid = 1'b1;
        tick();
        bus.pix_valid = 1'b0;
        tick();
        check(name, 32'(bus.color), 32'(exp));
    endtask

    task automatic frame_pulse();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        logic [23:0] fexp;
        int cnt;

        bus.pix_valid = 1'b0; bus.frame_start = 1'b0;
        bus.x = '0; bus.y = '0;
        bus.ballx = 10'd600; bus.bally = 10'd300;
        bus.paddlex = 10'd100; bus.paddley = 10'd400;
        bus.alive = '1;
        reset_model();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_color", 32'(bus.color), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        rst = 1'b1;

        // Idle: brick pixel renders black, valid still tracks by 2.
        for (int i = 0; i < 4; i++) begin
            bus.pix_valid = 1'($urandom_range(0, 1));
            bus.x = 10'd41; bus.y = 10'd45;
            tick();
        end
        probe(41, 45, "idle_color", 24'h0);
        check("idle_state", 32'(state), 32'(ST_IDLE));

        start_n = 1'b0;
        tick();
        check("run_state", 32'(state), 32'(ST_RUN));

        // Fixed vectors.
        vecs.push_back('{41, 45, 600, 300, 100, 400, 24'hFF0000});
        vecs.push_back('{121, 45, 600, 300, 100, 400, 24'hFFFFFF});
        vecs.push_back('{41, 95, 600, 300, 100, 400, 24'hFFFFFF});
        vecs.push_back('{201, 145, 600, 300, 100, 400, 24'hFF0000});
        vecs.push_back('{639, 189, 600, 300, 100, 400, 24'hFFFFFF});
        vecs.push_back('{0, 45, 600, 300, 100, 400, 24'h000000});
        vecs.push_back('{80, 45, 600, 300, 100, 400, 24'h000000});
        vecs.push_back('{41, 40, 600, 300, 100, 400, 24'h000000});
        vecs.push_back('{640, 100, 600, 300, 100, 400, 24'h000000});
        vecs.push_back('{150, 405, 600, 300, 100, 400, 24'hFFFFFF});
        vecs.push_back('{100, 405, 600, 300, 100, 400, 24'h000000});
        vecs.push_back('{259, 409, 600, 300, 100, 400, 24'hFFFFFF});
        vecs.push_back('{260, 405, 600, 300, 100, 400, 24'h000000});
        vecs.push_back('{150, 410, 600, 300, 100, 400, 24'h000000});
        vecs.push_back('{45, 45, 45, 45, 100, 400, 24'hFFFFFF});
        vecs.push_back('{0, 300, 1, 300, 100, 400, 24'hFFFFFF});
        vecs.push_back('{602, 302, 600, 300, 100, 400, 24'hFFFFFF});
        vecs.push_back('{603, 300, 600, 300, 100, 400, 24'h000000});
        vecs.push_back('{95, 45, 85, 45, 100, 400, 24'hFFFFFF});
        foreach (vecs[i]) begin
            bus.ballx = XW'(vecs[i].bx); bus.bally = XW'(vecs[i].by);
            bus.paddlex = XW'(vecs[i].padx); bus.paddley = XW'(vecs[i].pady);
            probe(vecs[i].px, vecs[i].py, $sformatf("vec%0d", i), vecs[i].exp);
        end
        bus.ballx = 10'd600; bus.bally = 10'd300;

        // Brick 0 destroyed: same-cycle pixel still sees it alive.
        bus.alive = ~24'd1;
        bus.frame_start = 1'b1;
        bus.x = 10'd41; bus.y = 10'd45; bus.pix_valid = 1'b1;
        tick();
        bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
        tick();
        check("fs_same_cycle", 32'(bus.color), 32'(C_A));

        // Flash: counter 8,7,...,0 blinks on odd values, then stays dark.
        for (int i = 0; i < 10; i++) begin
            cnt  = (8 - i > 0) ? 8 - i : 0;
            fexp = (cnt % 2 == 1) ? C_FL : 24'h0;
            probe(41, 45, $sformatf("flash%0d", i), fexp);
            frame_pulse();
        end
        bus.alive = '1;
        frame_pulse();
        probe(41, 45, "brick_back", C_A);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bus.pix_valid = ($urandom_range(0, 3) != 0);
            bus.frame_start = ($urandom_range(0, 11) == 0);
            if (bus.frame_start) begin
                if ($urandom_range(0, 1) == 0) bus.alive[$urandom_range(0, NB - 1)] = 1'b0;
                if ($urandom_range(0, 9) == 0) bus.alive = '1;
                bus.ballx   = XW'($urandom_range(0, 650));
                bus.bally   = XW'($urandom_range(0, 450));
                bus.paddlex = XW'($urandom_range(0, 600));
                bus.paddley = XW'($urandom_range(0, 450));
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.x = XW'(int'(bus.ballx) + $urandom_range(0, 8));
                bus.y = XW'(int'(bus.bally) + $urandom_range(0, 8));
                bus.x = (bus.x >= 10'd4) ? bus.x - 10'd4 : 10'd0;
                bus.y = (bus.y >= 10'd4) ? bus.y - 10'd4 : 10'd0;
            end else begin
                bus.x = XW'($urandom_range(0, 700));
                bus.y = XW'($urandom_range(0, 460));
            end
            tick();
        end
        bus.frame_start = 1'b0;

        // Reset in the middle of a valid stream.
        bus.x = 10'd41; bus.y = 10'd45; bus.pix_valid = 1'b1;
        bus.alive = '1;
        tick(); tick(); tick();
        start_n = 1'b1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_color", 32'(bus.color), 32'd0);
        check("midrst_state", 32'(state), 32'(ST_IDLE));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        reset_model();
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_idle", 32'(state), 32'(ST_IDLE));
        check("post_rst_color", 32'(bus.color), 32'd0);
        start_n = 1'b0;
        tick();
        check("post_rst_run", 32'(state), 32'(ST_RUN));
        probe(121, 45, "post_rst_brick", C_B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/breakout_pixel_renderer.md
# breakout_pixel_renderer

Parametrised, pipelined pixel colour generator for the Breakout display path: maps each VGA scan coordinate to a 24-bit RGB value from paddle, ball and a ROWS×COLS brick grid. Sits between the VGA timing generator (x, y, pix_valid, frame_start) and the game-logic block (ball/paddle positions, brick alive bitmap). Adds a fixed 2-cycle pipeline with valid tracking, and per-brick destruction flash driven by frame counters.

## Interface
- XW, 10, coordinate width (x, y, positions)
- ROWS, 3, brick rows
- COLS, 8, brick columns
- BLK_W, 80, brick pitch in x (pixels)
- BLK_H, 50, brick pitch in y
- GRID_X0, 0, left edge of grid
- GRID_Y0, 40, top edge of grid
- PAD_W, 160, paddle width
- PAD_H, 10, paddle height
- BALL_R, 3, ball half-size
- FLASH_FRAMES, 8, flash duration in frames; 0 disables flash
- COLOR_A / COLOR_B / COLOR_HI / COLOR_FLASH, 24'hFF0000 / 24'hFFFFFF / 24'hFFFFFF / 24'hFFFF00
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- start_n  in  1  active-low game start
- pix_valid  in  1  x/y valid this cycle
- frame_start  in  1  one-cycle pulse at frame start
- x, y  in  XW  scan coordinate
- ballx, bally  in  XW  ball centre
- paddlex, paddley  in  XW  paddle top-left
- alive  in  ROWS*COLS  brick present; bit r*COLS+c
- out_valid  out  1  color valid
- color  out  24  RGB

## Operation
- FSM: IDLE, RUN. Reset → IDLE. IDLE→RUN when start_n==0 (sampled). RUN holds until reset. No other states; illegal encoding → IDLE.
- IDLE: color forced 0; pipeline and out_valid still run.
- Stage 1 (registered): paddle hit = x>paddlex && x<paddlex+PAD_W && y>paddley && y<paddley+PAD_H. Ball hit = x>ballx−BALL_R && x<ballx+BALL_R, same in y. Column index c = highest c with x ≥ GRID_X0+c·BLK_W (constant compare chain, no divider); row likewise; in_grid when both within range. Brick interior strict: x>base_x && x<base_x+BLK_W (1-px gutter on left/top edges).
- All compares in XW+2 bits signed; ballx<BALL_R must not wrap (x=0 hits ball at ballx=1).
- Stage 2: priority paddle → COLOR_HI, ball → COLOR_HI, live brick → COLOR_A if (r+c) even else COLOR_B, flashing brick with flash_cnt[0]==1 → COLOR_FLASH, else 0.
- alive_q sampled on frame_start only; render uses alive_q, never raw alive.
- Flash: per brick, counter width clog2(FLASH_FRAMES+1). On frame_start: if alive_q=1 and alive=0 load FLASH_FRAMES; else if alive=1 clear; else decrement if nonzero.

## Timing
- Latency 2 cycles: out_valid(t+2)=pix_valid(t); color meaningful only when out_valid=1.
- Reset values: out_valid 0, color 0, alive_q all 1, flash counters 0, FSM IDLE, pipeline valids 0.
- frame_start and pix_valid same cycle: that pixel uses pre-update alive_q/counters.
- Position inputs sampled in stage 1 with x/y; no synchronisation required beyond frame-stable drive.
- Reset mid-frame: outputs clear immediately (async); pipeline contents discarded.
- FLASH_FRAMES=0: destroyed brick vanishes at next frame_start.

## Structure
- Package breakout_pkg: colour constants, FSM state enum, brick index function (r*COLS+c), clog2 helper.
- Sub-module brick_flash_ctr (one instance per brick via generate): frame-driven load/decrement counter.

## Test plan
- Reset, start_n=0, pixel (41,45) valid → 2 cycles later out_valid=1, color FF0000; (121,45) → FFFFFF; (41,95) → FFFFFF.
- paddlex=100, paddley=400, pixel (150,405) → FFFFFF; (100,405) edge → 000000.
- Ball at (45,45) over brick 0, pixel (45,45) → COLOR_HI; ballx=1, bally=300, pixel (0,300) → FFFFFF (no wrap).
- alive[0] 1→0, then 9 frame_starts probing (41,45) each frame → FFFF00 on odd counts (8,…: 0,FFFF00,0,…) then 000000 after counter expiry.
- Hold start_n=1: all pixels → 000000, out_valid follows pix_valid by 2.
- Assert rst mid-stream with pix_valid=1 → out_valid and color 0 same cycle; FSM IDLE until start_n=0.
